// File: rtl/jal_pkg.sv
// Shared definitions for the jal/jr return-address prediction path.
package jal_pkg;

  localparam int unsigned RAS_ADDR_W = 32;

  // $ra in the MIPS register file; only jr through this register pops the RAS.
  localparam logic [4:0] RA_REG = 5'd31;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_REPLACE
  } ras_op_t;

  function automatic ras_op_t ras_decode(input logic push, input logic pop);
    unique case ({push, pop})
      2'b10:   return RAS_PUSH;
      2'b01:   return RAS_POP;
      2'b11:   return RAS_REPLACE;
      default: return RAS_NONE;
    endcase
  endfunction

  // Qualifies a fetched jr as a return: only jr $ra consults the stack.
  function automatic logic ras_pop_qual(input logic is_jr, input logic [4:0] rs);
    return is_jr && (rs == RA_REG);
  endfunction

endpackage

// File: rtl/jal_ras_mem.sv
// DEPTH x ADDR_W register file: one synchronous write port, one async read port.
module jal_ras_mem #(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  // Clear wipes every entry and overrides any write in the same cycle.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jal_ras.sv
// Circular return-address stack: jal/jalr push PC+4, jr $ra pops the prediction.
// Optional checkpoint/restore ports exist only when JAL_RAS_CHECKPOINT_EN is defined.
module jal_ras
  import jal_pkg::*;
#(
  parameter  int unsigned ADDR_W = RAS_ADDR_W,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
`ifdef JAL_RAS_CHECKPOINT_EN
  input  logic              ckpt,
  input  logic              restore,
  output logic              ckpt_busy,
`endif
  output logic [ADDR_W-1:0] top_addr,
  output logic              top_valid,
  output logic              full,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  tos_q, tos_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              mem_clr, mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [ADDR_W-1:0] mem_wdata, mem_rdata;

  logic    empty, is_full;
  ras_op_t op;

  assign empty   = (count_q == '0);
  assign is_full = (count_q == FULL_CNT);
  assign op      = ras_decode(push, pop);

`ifdef JAL_RAS_CHECKPOINT_EN
  logic [PTR_W-1:0]  snap_tos_q;
  logic [PTR_W:0]    snap_cnt_q;
  logic [ADDR_W-1:0] snap_data_q;
  logic              snap_vld_q;
  logic              busy_q;
`endif

  // Next-state decode of the stack pointer, occupancy, write port and event flags.
  always_comb begin
    tos_d     = tos_q;
    count_d   = count_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    mem_clr   = reset;
    mem_we    = 1'b0;
    mem_waddr = tos_q;
    mem_wdata = push_addr;
    unique case (op)
      RAS_PUSH: begin
        tos_d     = tos_q + 1'b1;
        mem_waddr = tos_q + 1'b1;
        mem_we    = 1'b1;
        if (is_full) ovf_d   = 1'b1;
        else         count_d = count_q + 1'b1;
      end
      RAS_POP: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          tos_d   = tos_q - 1'b1;
          count_d = count_q - 1'b1;
        end
      end
      RAS_REPLACE: begin
        mem_we = 1'b1;
        // Replacing on an empty stack degenerates to a plain push.
        if (empty) begin
          tos_d     = tos_q + 1'b1;
          mem_waddr = tos_q + 1'b1;
          count_d   = count_q + 1'b1;
        end
      end
      default: ;
    endcase
`ifdef JAL_RAS_CHECKPOINT_EN
    // Restore overrides push/pop; without a snapshot it rebuilds the reset state.
    if (restore) begin
      tos_d     = snap_tos_q;
      count_d   = snap_cnt_q;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      mem_we    = snap_vld_q;
      mem_waddr = snap_tos_q;
      mem_wdata = snap_data_q;
      if (!snap_vld_q) mem_clr = 1'b1;
    end
`endif
  end

  // Stack pointer, occupancy and one-cycle event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef JAL_RAS_CHECKPOINT_EN
  // Snapshot of {tos, count, entry[tos]}; busy tracks an outstanding checkpoint.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_tos_q  <= '0;
      snap_cnt_q  <= '0;
      snap_data_q <= '0;
      snap_vld_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else if (restore) begin
      busy_q <= 1'b0;
    end else if (ckpt) begin
      snap_tos_q  <= tos_q;
      snap_cnt_q  <= count_q;
      snap_data_q <= mem_rdata;
      snap_vld_q  <= 1'b1;
      busy_q      <= 1'b1;
    end
  end

  assign ckpt_busy = busy_q;
`endif

  jal_ras_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .clr_i   (mem_clr),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (tos_q),
    .rdata_o (mem_rdata)
  );

  assign top_addr  = empty ? '0 : mem_rdata;
  assign top_valid = !empty;
  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_jal_ras.sv
// Self-checking bench for jal_ras (default DEPTH=8, ADDR_W=32).
// Checkpoint scenario is compiled in when JAL_RAS_CHECKPOINT_EN is defined.
module tb_jal_ras;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, push, pop;
  logic [31:0] push_addr;
  logic [31:0] top_addr;
  logic        top_valid, full, overflow, underflow;
  logic [3:0]  count;
`ifdef JAL_RAS_CHECKPOINT_EN
  logic        ckpt, restore, ckpt_busy;
`endif

  int checks   = 0;
  int failures = 0;

  // Scoreboard: back = expected top entry, front = oldest entry.
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  jal_ras #(.ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (push_addr),
    .pop       (pop),
`ifdef JAL_RAS_CHECKPOINT_EN
    .ckpt      (ckpt),
    .restore   (restore),
    .ckpt_busy (ckpt_busy),
`endif
    .top_addr  (top_addr),
    .top_valid (top_valid),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Drive one cycle of stimulus, then return 1ns after the edge.
  task automatic cyc(input logic p, input logic [31:0] a, input logic q);
    push = p; push_addr = a; pop = q;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; push_addr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    cyc(0, 0, 0);
    checks++; if (top_valid !== 1'b0) begin failures++; $display("FAIL reset_top_valid got=%b exp=0", top_valid); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (top_addr !== 32'h0) begin failures++; $display("FAIL reset_top_addr got=%h exp=0", top_addr); end
    checks++; if ({full, overflow, underflow} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {full, overflow, underflow}); end
  endtask

  task automatic test_push_pop();
    cyc(1, 32'h8, 0); exp_q.push_back(32'h8);
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL pp_count1 got=%0d exp=1", count); end
    pop = 1'b1; #1;
    checks++; if (top_addr !== exp_q[$]) begin failures++; $display("FAIL pp_top got=%h exp=%h", top_addr, exp_q[$]); end
    void'(exp_q.pop_back());
    @(posedge clk); #1; pop = 1'b0;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL pp_count0 got=%0d exp=0", count); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL pp_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_lifo();
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 32'(i * 16), 0); exp_q.push_back(32'(i * 16));
    end
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1; #1;
      checks++; if (top_addr !== exp_q[$]) begin failures++; $display("FAIL lifo_top%0d got=%h exp=%h", i, top_addr, exp_q[$]); end
      void'(exp_q.pop_back());
      @(posedge clk); #1; pop = 1'b0;
    end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL lifo_count got=%0d exp=0", count); end
  endtask

  task automatic test_overflow();
    logic exp_ovf;
    int   ovf_seen = 0;
    for (int i = 1; i <= 9; i++) begin
      exp_ovf = (exp_q.size() == DEPTH);
      if (exp_ovf) void'(exp_q.pop_front());
      exp_q.push_back(32'(i * 4));
      cyc(1, 32'(i * 4), 0);
      if (overflow) ovf_seen++;
      checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL ovf_pulse%0d got=%b exp=%b", i, overflow, exp_ovf); end
    end
    cyc(0, 0, 0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle got=%b exp=0", overflow); end
    checks++; if (ovf_seen != 1) begin failures++; $display("FAIL ovf_count got=%0d exp=1", ovf_seen); end
    checks++; if (count !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%0d/%b exp=8/1", count, full); end
    for (int i = 0; i < DEPTH; i++) begin
      pop = 1'b1; #1;
      checks++; if (top_addr !== exp_q[$]) begin failures++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, top_addr, exp_q[$]); end
      void'(exp_q.pop_back());
      @(posedge clk); #1; pop = 1'b0;
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL ovf_pop_unf%0d got=%b exp=0", i, underflow); end
    end
    cyc(0, 0, 1);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_pulse got=%b exp=1", underflow); end
    checks++; if (count !== 4'd0 || top_addr !== 32'h0) begin failures++; $display("FAIL unf_state got=%0d/%h exp=0/0", count, top_addr); end
    cyc(0, 0, 0);
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL unf_one_cycle got=%b exp=0", underflow); end
  endtask

  task automatic test_replace();
    cyc(1, 32'h40, 0); exp_q.push_back(32'h40);
    cyc(1, 32'h80, 1); exp_q[exp_q.size()-1] = 32'h80;
    checks++; if (top_addr !== exp_q[$]) begin failures++; $display("FAIL repl_top got=%h exp=%h", top_addr, exp_q[$]); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL repl_count got=%0d exp=1", count); end
    cyc(0, 0, 1); void'(exp_q.pop_back());
    // Replace on an empty stack acts as a push and raises no underflow.
    cyc(1, 32'h44, 1); exp_q.push_back(32'h44);
    checks++; if (top_addr !== exp_q[$] || count !== 4'd1) begin failures++; $display("FAIL repl_empty got=%h/%0d exp=%h/1", top_addr, count, exp_q[$]); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL repl_empty_unf got=%b exp=0", underflow); end
  endtask

  task automatic test_back_to_back();
    cyc(1, 32'h100, 0); exp_q.push_back(32'h100);
    cyc(1, 32'h104, 0); exp_q.push_back(32'h104);
    checks++; if (count !== 4'(exp_q.size())) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", count, exp_q.size()); end
    // Reset with a push pending: reset wins and all entries are discarded.
    push = 1'b1; push_addr = 32'h200;
    do_reset();
    push = 1'b0;
    checks++; if (count !== 4'd0 || top_valid !== 1'b0 || top_addr !== 32'h0) begin failures++; $display("FAIL mid_reset got=%0d/%b/%h exp=0/0/0", count, top_valid, top_addr); end
  endtask

`ifdef JAL_RAS_CHECKPOINT_EN
  task automatic test_checkpoint();
    do_reset();
    cyc(1, 32'h8, 0);
    ckpt = 1'b1; cyc(0, 0, 0); ckpt = 1'b0;
    checks++; if (ckpt_busy !== 1'b1) begin failures++; $display("FAIL ckpt_busy got=%b exp=1", ckpt_busy); end
    cyc(1, 32'hC, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    restore = 1'b1; cyc(1, 32'hDEAD, 0); restore = 1'b0;
    checks++; if (top_addr !== 32'h8 || count !== 4'd1) begin failures++; $display("FAIL ckpt_restore got=%h/%0d exp=00000008/1", top_addr, count); end
    checks++; if (ckpt_busy !== 1'b0) begin failures++; $display("FAIL ckpt_busy_clr got=%b exp=0", ckpt_busy); end
    // Restore without a snapshot since reset returns to the reset state.
    do_reset();
    cyc(1, 32'h50, 0);
    restore = 1'b1; cyc(0, 0, 0); restore = 1'b0;
    checks++; if (count !== 4'd0 || top_addr !== 32'h0) begin failures++; $display("FAIL ckpt_nosnap got=%0d/%h exp=0/0", count, top_addr); end
  endtask
`endif

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; push_addr = '0;
`ifdef JAL_RAS_CHECKPOINT_EN
    ckpt = 1'b0; restore = 1'b0;
`endif
    test_reset();
    test_push_pop();
    test_lifo();
    test_overflow();
    test_replace();
    test_back_to_back();
`ifdef JAL_RAS_CHECKPOINT_EN
    test_checkpoint();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jal_ras.md
Name: jal_ras

Overview:
- Parametrised return-address stack (RAS) for the MIPS datapath.
- Successor to the plain jal link path: the fetch stage now predicts `jr $ra` targets instead of waiting for the register file.
- `jal`/`jalr` push the link address (PC+4); `jr $ra` pops the predicted target.
- Sits beside the PC-select mux in the processor top; single clock domain.

Parameters:
- ADDR_W, 32, width of stored return addresses.
- DEPTH, 8, number of stack entries; must be a power of two, >= 2.
- PTR_W, $clog2(DEPTH), top-of-stack pointer width (derived, not overridden).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears the stack on the next rising edge.
- push  input  1  jal/jalr retiring this cycle; store push_addr.
- push_addr  input  ADDR_W  link address (PC+4) to store.
- pop  input  1  jr $ra fetched this cycle; remove top entry.
- top_addr  output  ADDR_W  predicted return target; combinational read of the current top entry; 0 when empty.
- top_valid  output  1  high when count > 0.
- full  output  1  count == DEPTH.
- count  output  PTR_W+1  number of valid entries.
- overflow  output  1  one-cycle pulse: a push while full overwrote the oldest entry.
- underflow  output  1  one-cycle pulse: a pop while empty.

Behaviour:
- Reset (synchronous): tos = 0, count = 0, overflow = 0, underflow = 0, every entry cleared to 0. Therefore top_addr = 0, top_valid = 0, full = 0.
- Storage is circular. tos points at the current top entry and wraps modulo DEPTH.
- Push only:
  - tos <= tos+1; entry[tos+1] <= push_addr.
  - count <= min(count+1, DEPTH).
  - If count == DEPTH beforehand, the oldest entry is silently overwritten, count stays DEPTH, and overflow pulses.
- Pop only:
  - If count > 0: tos <= tos-1 (wrapping), count <= count-1; the entry is not cleared.
  - If count == 0: no state change and underflow pulses.
- Push and pop together (jalr through $ra, or back-to-back retire/fetch): replace the top.
  - entry[tos] <= push_addr; tos and count unchanged.
  - If count == 0, behave as push only; underflow does not pulse.
- Latency: a push is visible on top_addr the cycle after the edge. The pop consumer uses top_addr in the same cycle it asserts pop.
- Reset has priority over push and pop in the same cycle.
- Reset mid-sequence discards all entries.
- overflow and underflow are registered and high for exactly one cycle per event.

Optional Feature:
- Macro: JAL_RAS_CHECKPOINT_EN.
- When defined, add the following ports:
  - ckpt input 1
  - restore input 1
  - ckpt_busy output 1
- ckpt snapshots {tos, count, entry[tos]}.
- restore (branch-mispredict flush) reloads the snapshot on the next edge; push and pop are ignored in that cycle.
- restore with no prior snapshot since reset restores the reset state.
- ckpt_busy is high from ckpt until restore or the next ckpt. It is informational only and does not block either port.
- Without the macro, none of these ports or registers exist.

Decomposition:
- Shared package jal_pkg:
  - default ADDR_W = 32.
  - typedef ras_op_t {RAS_NONE, RAS_PUSH, RAS_POP, RAS_REPLACE}, decoded from {push, pop}.
  - constant RA_REG = 5'd31, used by decode to qualify pop.
- One natural sub-module: jal_ras_mem, a DEPTH x ADDR_W register file with one synchronous write port and one asynchronous read port.

Test Plan:
- Reset held for 2 cycles, then idle → top_valid=0, count=0, top_addr=0.
- push 0x00000008, then next cycle pop → top_addr=0x8 in the pop cycle; count goes 1→0; underflow stays 0.
- push 0x10, 0x20, 0x30; pop ×3 → top_addr reads 0x30, 0x20, 0x10 in turn; count ends at 0.
- DEPTH=8: push 0x4..0x24 (9 pushes, step 4) → overflow pulses once on the 9th push; count=8; 8 pops return 0x24 down to 0x8; a 9th pop pulses underflow.
- Stack holding 0x40: push 0x80 and pop in the same cycle → top_addr=0x80, count=1.
- With JAL_RAS_CHECKPOINT_EN: push 0x8, ckpt, push 0xC, pop, pop, restore → top_addr=0x8, count=1.
